dmem_arbiter: RTL and testbench

Two-requester arbiter for the single-port data memory. It sits between the memory stage (via the peripheral bus, data-memory chip-select path) and a second bus master (DMA/program loader). It grants one requester per cycle with core priority and a bounded-starvation guarantee for the DMA port. It stalls the core when the core is denied, and returns registered read data to the DMA port.

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 71 +++++++
 tb/tb_dmem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// slave = arbiter view; master = requesters plus memory.
interface dmem_arbiter_if #(
    parameter int DW    = 32,
    parameter int ADDRW = 8
);
    logic             core_req_i;
    logic             core_we_i;
    logic [3:0]       core_mask_i;
    logic [ADDRW-1:0] core_addr_i;
    logic [DW-1:0]    core_wdata_i;
    logic [DW-1:0]    core_rdata_o;
    logic             core_stall_o;

    logic             dma_req_i;
    logic             dma_we_i;
    logic [3:0]       dma_mask_i;
    logic [ADDRW-1:0] dma_addr_i;
    logic [DW-1:0]    dma_wdata_i;
    logic             dma_gnt_o;
    logic             dma_rvalid_o;
    logic [DW-1:0]    dma_rdata_o;

    logic             mem_cs_o;
    logic             mem_we_o;
    logic [3:0]       mem_mask_o;
    logic [ADDRW-1:0] mem_addr_o;
    logic [DW-1:0]    mem_wdata_o;
    logic [DW-1:0]    mem_rdata_i;

    modport slave (
        input  core_req_i, core_we_i, core_mask_i, core_addr_i, core_wdata_i,
        output core_rdata_o, core_stall_o,
        input  dma_req_i, dma_we_i, dma_mask_i, dma_addr_i, dma_wdata_i,
        output dma_gnt_o, dma_rvalid_o, dma_rdata_o,
        output mem_cs_o, mem_we_o, mem_mask_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output core_req_i, core_we_i, core_mask_i, core_addr_i, core_wdata_i,
        input  core_rdata_o, core_stall_o,
        output dma_req_i, dma_we_i, dma_mask_i, dma_addr_i, dma_wdata_i,
        input  dma_gnt_o, dma_rvalid_o, dma_rdata_o,
        input  mem_cs_o, mem_we_o, mem_mask_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: core has priority, DMA is forced through
// after STARVE_MAX contested losses. DMA reads return registered data one cycle later.
module dmem_arbiter #(
    parameter int DW         = 32,
    parameter int ADDRW      = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dmem_arbiter_if.slave  bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]       starve_cnt_q, starve_cnt_d;
    logic             dma_rvalid_q, dma_rvalid_d;
    logic [DW-1:0]    dma_rdata_q, dma_rdata_d;

    logic             force_dma, gnt_core, gnt_dma;
    logic             mem_cs, mem_we;
    logic [3:0]       mem_mask;
    logic [ADDRW-1:0] mem_addr;
    logic [DW-1:0]    mem_wdata;

    always_comb begin
        force_dma = bus.dma_req_i && (starve_cnt_q == STARVE_LIM);
        gnt_core  = bus.core_req_i && !force_dma;
        gnt_dma   = bus.dma_req_i && !gnt_core;
    end

    // Idle cycles present the core fields; only cs/we need to be quiet.
    always_comb begin
        mem_cs    = gnt_core || gnt_dma;
        mem_we    = gnt_dma ? bus.dma_we_i : (gnt_core && bus.core_we_i);
        mem_mask  = gnt_dma ? bus.dma_mask_i  : bus.core_mask_i;
        mem_addr  = gnt_dma ? bus.dma_addr_i  : bus.core_addr_i;
        mem_wdata = gnt_dma ? bus.dma_wdata_i : bus.core_wdata_i;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (gnt_dma)
            starve_cnt_d = 4'd0;
        else if (bus.dma_req_i && (starve_cnt_q != STARVE_LIM))
            starve_cnt_d = starve_cnt_q + 4'd1;
        dma_rvalid_d = gnt_dma && !bus.dma_we_i;
        dma_rdata_d  = dma_rvalid_d ? bus.mem_rdata_i : dma_rdata_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            starve_cnt_q <= 4'd0;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign bus.mem_cs_o     = mem_cs;
    assign bus.mem_we_o     = mem_we;
    assign bus.mem_mask_o   = mem_mask;
    assign bus.mem_addr_o   = mem_addr;
    assign bus.mem_wdata_o  = mem_wdata;
    assign bus.core_rdata_o = bus.mem_rdata_i;
    assign bus.core_stall_o = bus.core_req_i && !gnt_core;
    assign bus.dma_gnt_o    = gnt_dma;
    assign bus.dma_rvalid_o = dma_rvalid_q;
    assign bus.dma_rdata_o  = dma_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expected values queued per step, checked against the DUT.
module tb_dmem_arbiter;
    localparam int DW = 32;
    localparam int ADDRW = 8;

    logic clk;
    logic rst_n;
    logic [DW-1:0] mem [256];

    dmem_arbiter_if #(.DW(DW), .ADDRW(ADDRW)) bus ();
    dmem_arbiter #(.DW(DW), .ADDRW(ADDRW), .STARVE_MAX(4)) dut (
        .clk_i(clk), .rst_i(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory with byte mask.
    assign bus.mem_rdata_i = mem[bus.mem_addr_o];
    always @(posedge clk)
        if (bus.mem_cs_o && bus.mem_we_o)
            for (int b = 0; b < 4; b++)
                if (bus.mem_mask_o[b]) mem[bus.mem_addr_o][b*8 +: 8] <= bus.mem_wdata_o[b*8 +: 8];

    localparam int S_STALL = 0, S_GNT = 1, S_RVLD = 2, S_DRDATA = 3, S_CRDATA = 4, S_CS = 5, S_WE = 6;

    typedef struct {
        string         tag;
        int            sel;
        logic [DW-1:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [DW-1:0] observe(int sel);
        case (sel)
            S_STALL:  return {31'd0, bus.core_stall_o};
            S_GNT:    return {31'd0, bus.dma_gnt_o};
            S_RVLD:   return {31'd0, bus.dma_rvalid_o};
            S_DRDATA: return bus.dma_rdata_o;
            S_CRDATA: return bus.core_rdata_o;
            S_CS:     return {31'd0, bus.mem_cs_o};
            S_WE:     return {31'd0, bus.mem_we_o};
            default:  return 'x;
        endcase
    endfunction

    task automatic expect_v(string tag, int sel, logic [DW-1:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = v;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [DW-1:0] o;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            o = observe(e.sel);
            n_vec++;
            assert (o === e.val) else begin
                n_bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_drv(input logic req, input logic we, input logic [3:0] m,
                            input logic [ADDRW-1:0] a, input logic [DW-1:0] d);
        bus.core_req_i = req; bus.core_we_i = we; bus.core_mask_i = m;
        bus.core_addr_i = a; bus.core_wdata_i = d;
    endtask

    task automatic dma_drv(input logic req, input logic we, input logic [3:0] m,
                           input logic [ADDRW-1:0] a, input logic [DW-1:0] d);
        bus.dma_req_i = req; bus.dma_we_i = we; bus.dma_mask_i = m;
        bus.dma_addr_i = a; bus.dma_wdata_i = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst_n = 1'b0;
        core_drv(0, 0, 4'h0, 8'h00, 32'h0);
        dma_drv(0, 0, 4'h0, 8'h00, 32'h0);

        #3;
        expect_v("reset_rvalid", S_RVLD, 0);
        expect_v("reset_rdata", S_DRDATA, 0);
        drain();
        #9 rst_n = 1'b1;
        tick();

        // core store then load
        core_drv(1, 1, 4'hF, 8'h10, 32'hDEADBEEF);
        #1;
        expect_v("core_st_stall", S_STALL, 0);
        expect_v("core_st_cs", S_CS, 1);
        expect_v("core_st_we", S_WE, 1);
        drain();
        tick();
        core_drv(1, 0, 4'hF, 8'h10, 32'h0);
        #1;
        expect_v("core_ld_stall", S_STALL, 0);
        expect_v("core_ld_data", S_CRDATA, 32'hDEADBEEF);
        expect_v("core_ld_we", S_WE, 0);
        drain();
        tick();

        // DMA write then read
        core_drv(0, 0, 4'h0, 8'h00, 32'h0);
        dma_drv(1, 1, 4'hF, 8'h20, 32'h12345678);
        #1;
        expect_v("dma_wr_gnt", S_GNT, 1);
        expect_v("dma_wr_we", S_WE, 1);
        expect_v("dma_wr_stall", S_STALL, 0);
        drain();
        tick();
        expect_v("dma_wr_no_rvalid", S_RVLD, 0);
        drain();
        dma_drv(1, 0, 4'hF, 8'h20, 32'h0);
        #1;
        expect_v("dma_rd_gnt", S_GNT, 1);
        expect_v("dma_rd_we", S_WE, 0);
        drain();
        tick();
        dma_drv(0, 0, 4'h0, 8'h00, 32'h0);
        #1;
        expect_v("dma_rd_rvalid", S_RVLD, 1);
        expect_v("dma_rd_data", S_DRDATA, 32'h12345678);
        drain();
        tick();
        expect_v("dma_rvalid_pulse_end", S_RVLD, 0);
        expect_v("dma_rdata_hold", S_DRDATA, 32'h12345678);
        drain();

        // partial DMA write over all-ones
        dma_drv(1, 1, 4'hF, 8'h30, 32'hFFFFFFFF);
        tick();
        dma_drv(1, 1, 4'b0011, 8'h30, 32'hAAAA5555);
        #1;
        expect_v("dma_part_gnt", S_GNT, 1);
        drain();
        tick();
        dma_drv(0, 0, 4'h0, 8'h00, 32'h0);
        core_drv(1, 0, 4'hF, 8'h30, 32'h0);
        #1;
        expect_v("partial_merge", S_CRDATA, 32'hFFFF5555);
        drain();
        tick();

        // starvation bound under continuous contention
        core_drv(1, 0, 4'hF, 8'h10, 32'h0);
        dma_drv(1, 0, 4'hF, 8'h20, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            #1;
            expect_v($sformatf("starve_c%0d_gnt", c), S_GNT, 0);
            expect_v($sformatf("starve_c%0d_stall", c), S_STALL, 0);
            expect_v($sformatf("starve_c%0d_crd", c), S_CRDATA, 32'hDEADBEEF);
            drain();
            tick();
        end
        #1;
        expect_v("starve_c5_gnt", S_GNT, 1);
        expect_v("starve_c5_stall", S_STALL, 1);
        expect_v("starve_c5_we", S_WE, 0);
        drain();
        tick();
        #1;
        expect_v("starve_c6_gnt", S_GNT, 0);
        expect_v("starve_c6_stall", S_STALL, 0);
        expect_v("starve_c6_rvalid", S_RVLD, 1);
        expect_v("starve_c6_rdata", S_DRDATA, 32'h12345678);
        drain();
        tick();
        core_drv(0, 0, 4'h0, 8'h00, 32'h0);
        #1;
        expect_v("clear_gnt", S_GNT, 1);
        drain();
        tick();

        // request drop: counter holds at 3
        core_drv(1, 0, 4'hF, 8'h10, 32'h0);
        dma_drv(1, 1, 4'hF, 8'h40, 32'h00000055);
        for (int c = 0; c < 3; c++) begin
            #1;
            expect_v($sformatf("drop_lose%0d", c), S_GNT, 0);
            drain();
            tick();
        end
        bus.dma_req_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            expect_v($sformatf("drop_idle%0d_gnt", c), S_GNT, 0);
            expect_v($sformatf("drop_idle%0d_stall", c), S_STALL, 0);
            drain();
            tick();
        end
        bus.dma_req_i = 1'b1;
        #1;
        expect_v("drop_last_lose", S_GNT, 0);
        drain();
        tick();
        #1;
        expect_v("drop_forced_gnt", S_GNT, 1);
        expect_v("drop_forced_stall", S_STALL, 1);
        expect_v("drop_forced_we", S_WE, 1);
        drain();
        tick();
        dma_drv(0, 0, 4'h0, 8'h00, 32'h0);
        core_drv(1, 0, 4'hF, 8'h40, 32'h0);
        #1;
        expect_v("drop_wr_landed", S_CRDATA, 32'h00000055);
        drain();
        tick();

        // back-to-back DMA reads
        core_drv(0, 0, 4'h0, 8'h00, 32'h0);
        dma_drv(1, 0, 4'hF, 8'h20, 32'h0);
        #1;
        expect_v("b2b_gnt0", S_GNT, 1);
        drain();
        tick();
        dma_drv(1, 0, 4'hF, 8'h30, 32'h0);
        #1;
        expect_v("b2b_gnt1", S_GNT, 1);
        expect_v("b2b_rvalid0", S_RVLD, 1);
        expect_v("b2b_rdata0", S_DRDATA, 32'h12345678);
        drain();
        tick();
        dma_drv(0, 0, 4'h0, 8'h00, 32'h0);
        #1;
        expect_v("b2b_rvalid1", S_RVLD, 1);
        expect_v("b2b_rdata1", S_DRDATA, 32'hFFFF5555);
        drain();
        tick();

        // reset between grant and rvalid cycle
        dma_drv(1, 0, 4'hF, 8'h40, 32'h0);
        #1;
        expect_v("rstrd_gnt", S_GNT, 1);
        drain();
        #2 rst_n = 1'b0;
        #1;
        expect_v("rstrd_rvalid_async", S_RVLD, 0);
        expect_v("rstrd_rdata_async", S_DRDATA, 0);
        expect_v("rstrd_gnt_comb", S_GNT, 1);
        drain();
        tick();
        expect_v("rstrd_pulse_lost", S_RVLD, 0);
        drain();
        rst_n = 1'b1;
        dma_drv(0, 0, 4'h0, 8'h00, 32'h0);
        tick();

        // counter cleared by asynchronous reset
        core_drv(1, 0, 4'hF, 8'h10, 32'h0);
        dma_drv(1, 0, 4'hF, 8'h20, 32'h0);
        for (int c = 0; c < 3; c++) tick();
        bus.dma_req_i = 1'b0;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        bus.dma_req_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            expect_v($sformatf("rstcnt_lose%0d", c), S_GNT, 0);
            drain();
            tick();
        end
        #1;
        expect_v("rstcnt_forced_gnt", S_GNT, 1);
        expect_v("rstcnt_forced_stall", S_STALL, 1);
        drain();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
